// File: rtl/input_vc_buffer.sv
// ---------------------------------------------------------------------------
// input_vc_buffer
//   Router input port. Link flits are steered into per-VC first-word-fall-
//   through FIFOs according to the VCID field in the top two bits of the flit.
//   Each VC head flit is presented to the route/switch logic. Every dequeue
//   returns one credit pulse to the upstream output VC controller. After reset
//   an init sequencer pulses all credit lines INIT_CREDITS times. This seeds
//   the upstream credit counters with the buffer space available here.
//
// Ports
//   clk           rising-edge clock for all logic
//   rstn          synchronous reset, active-low
//   in_valid      link flit valid
//   in_data       link flit: [DW-1:DW-2]=VCID, [DW-3:DW-4]=flit type
//   rd_en         per-VC dequeue request from the switch allocator
//   vc_valid      per-VC FIFO non-empty
//   vc_flit       per-VC head flit, VC v at [v*DW +: DW]
//   credit_upd    registered one-cycle credit pulse per VC, to upstream
//   init_done     high once credit seeding has finished
//   overflow_err  sticky: a flit was dropped (VC full or VCID out of range)
// ---------------------------------------------------------------------------
`ifndef BUF_DEPTH
`define BUF_DEPTH 4
`endif
`ifndef DW
`define DW 16
`endif

module input_vc_buffer #(
  parameter int VC_NUM       = 4,
  parameter int DEPTH        = `BUF_DEPTH,
  parameter int INIT_CREDITS = DEPTH,
  parameter int DW           = `DW
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  input  logic [DW-1:0]        in_data,
  input  logic [VC_NUM-1:0]    rd_en,
  output logic [VC_NUM-1:0]    vc_valid,
  output logic [VC_NUM*DW-1:0] vc_flit,
  output logic [VC_NUM-1:0]    credit_upd,
  output logic                 init_done,
  output logic                 overflow_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);
  localparam int CW = (INIT_CREDITS > 1) ? $clog2(INIT_CREDITS + 1) : 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   init_cnt;

  logic [DW-1:0]   mem    [VC_NUM][DEPTH];
  logic [PW-1:0]   wr_ptr [VC_NUM];
  logic [PW-1:0]   rd_ptr [VC_NUM];
  logic [OW-1:0]   occ    [VC_NUM];

  logic [VC_NUM-1:0] wr_ok;
  logic [VC_NUM-1:0] rd_ok;
  logic              drop;
  logic [1:0]        vcid;

  // Pointers wrap explicitly. This keeps a non-power-of-two DEPTH correct.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign vcid = in_data[DW-1:DW-2];

  // Per-VC write/read qualification. A full VC is judged on its occupancy
  // before the edge, so a simultaneous pop never makes room for a write.
  // VCIDs with no matching VC produce no wr_ok bit and are therefore dropped.
  always_comb begin
    wr_ok = '0;
    rd_ok = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      wr_ok[v] = in_valid && (vcid == 2'(v)) && (occ[v] < OW'(DEPTH));
      rd_ok[v] = (state == RUN) && rd_en[v] && (occ[v] != '0);
    end
    drop = in_valid && (wr_ok == '0);
  end

  // FIFO storage, pointers and occupancy. Reset clears the RAM as well,
  // so every head flit reads as zero until it is written.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int v = 0; v < VC_NUM; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        occ[v]    <= '0;
        for (int s = 0; s < DEPTH; s++) begin
          mem[v][s] <= '0;
        end
      end
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (wr_ok[v]) begin
          mem[v][wr_ptr[v]] <= in_data;
          wr_ptr[v]         <= next_ptr(wr_ptr[v]);
        end
        if (rd_ok[v]) begin
          rd_ptr[v] <= next_ptr(rd_ptr[v]);
        end
        if (wr_ok[v] && !rd_ok[v]) begin
          occ[v] <= occ[v] + 1'b1;
        end else if (!wr_ok[v] && rd_ok[v]) begin
          occ[v] <= occ[v] - 1'b1;
        end
      end
    end
  end

  // State register and init counter for the credit-seeding sequencer.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == INIT) begin
        init_cnt <= init_cnt + 1'b1;
      end
    end
  end

  // Leave INIT on the cycle that issues the last seeding pulse.
  // After that the sequencer stays in RUN until the next reset.
  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (init_cnt == CW'(INIT_CREDITS - 1)) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  // Registered status outputs. While seeding, every VC pulses credit on each
  // cycle. After seeding, each accepted pop pulses its own VC one cycle later.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      credit_upd   <= '0;
      init_done    <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      credit_upd   <= (state == INIT) ? '1 : rd_ok;
      init_done    <= (state == RUN);
      overflow_err <= overflow_err | drop;
    end
  end

  // Head presentation. vc_flit comes straight from the RAM head slot, so it
  // is meaningless whenever vc_valid is low.
  always_comb begin
    vc_valid = '0;
    vc_flit  = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      vc_valid[v]         = (occ[v] != '0);
      vc_flit[v*DW +: DW] = mem[v][rd_ptr[v]];
    end
  end

endmodule

// File: tb/tb_input_vc_buffer.sv
// ---------------------------------------------------------------------------
// tb_input_vc_buffer
//   Directed bench for input_vc_buffer (VC_NUM=4, DEPTH=4, DW=16).
//   A queue-based reference model tracks the contents of each VC, the expected
//   credits, the init status and the overflow flag. Every cycle after the first
//   reset, the DUT outputs are checked against that model. The directed
//   sequences also compare key outputs against hand-computed literal values.
// ---------------------------------------------------------------------------
module tb_input_vc_buffer;

  localparam int VC_NUM = 4;
  localparam int DEPTH  = 4;
  localparam int DW     = 16;
  localparam int INIT_CREDITS = DEPTH;

  logic                 clk;
  logic                 rstn;
  logic                 in_valid;
  logic [DW-1:0]        in_data;
  logic [VC_NUM-1:0]    rd_en;
  logic [VC_NUM-1:0]    vc_valid;
  logic [VC_NUM*DW-1:0] vc_flit;
  logic [VC_NUM-1:0]    credit_upd;
  logic                 init_done;
  logic                 overflow_err;

  int total = 0;
  int bad   = 0;

  input_vc_buffer #(
    .VC_NUM(VC_NUM),
    .DEPTH(DEPTH),
    .INIT_CREDITS(INIT_CREDITS),
    .DW(DW)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .in_valid(in_valid),
    .in_data(in_data),
    .rd_en(rd_en),
    .vc_valid(vc_valid),
    .vc_flit(vc_flit),
    .credit_upd(credit_upd),
    .init_done(init_done),
    .overflow_err(overflow_err)
  );

  // 10 ns clock. Stimulus changes 2 ns after each rising edge, and the model
  // compare runs on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [1:0] vc, input logic [1:0] ty,
                                       input logic [11:0] pl);
    return {vc, ty, pl};
  endfunction

  // Reference model: plain queues per VC plus a seeding countdown.
  logic [DW-1:0]     mq [VC_NUM][$];
  logic [VC_NUM-1:0] exp_credit;
  logic              exp_init_done;
  logic              exp_ovf;
  int                init_left;
  bit                model_ok = 0;

  always @(posedge clk) begin : model
    int sz_pre [VC_NUM];
    int vc;
    bit is_run;
    logic [DW-1:0] dummy;
    if (!rstn) begin
      for (int v = 0; v < VC_NUM; v++) mq[v].delete();
      exp_credit    = '0;
      exp_init_done = 1'b0;
      exp_ovf       = 1'b0;
      init_left     = INIT_CREDITS;
      model_ok      = 1;
    end else if (model_ok) begin
      is_run = (init_left == 0);
      for (int v = 0; v < VC_NUM; v++) sz_pre[v] = mq[v].size();
      exp_credit = '0;
      for (int v = 0; v < VC_NUM; v++) begin
        if (is_run && rd_en[v] && sz_pre[v] > 0) begin
          dummy = mq[v].pop_front();
          exp_credit[v] = 1'b1;
        end
      end
      if (in_valid) begin
        vc = int'(in_data[DW-1:DW-2]);
        if (vc < VC_NUM && sz_pre[vc] < DEPTH) mq[vc].push_back(in_data);
        else exp_ovf = 1'b1;
      end
      exp_init_done = is_run;
      if (init_left > 0) begin
        exp_credit = '1;
        init_left--;
      end
    end
  end

  always @(negedge clk) begin : compare
    if (model_ok) begin
      for (int v = 0; v < VC_NUM; v++) begin
        checkOutput($sformatf("vc_valid[%0d]", v), 64'(vc_valid[v]),
                    64'(mq[v].size() > 0));
        if (mq[v].size() > 0)
          checkOutput($sformatf("vc_flit[%0d]", v), 64'(vc_flit[v*DW +: DW]),
                      64'(mq[v][0]));
      end
      checkOutput("credit_upd", 64'(credit_upd), 64'(exp_credit));
      checkOutput("init_done", 64'(init_done), 64'(exp_init_done));
      checkOutput("overflow_err", 64'(overflow_err), 64'(exp_ovf));
    end
  end

  task automatic applyStimulus(input logic v, input logic [DW-1:0] d,
                               input logic [VC_NUM-1:0] r);
    in_valid = v;
    in_data  = d;
    rd_en    = r;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, '0);
  endtask

  initial begin
    int cnt;
    logic [DW-1:0] head_f, body_f, tail_f;
    head_f = mk(2'd2, 2'b01, 12'h0A1);
    body_f = mk(2'd2, 2'b10, 12'h0B2);
    tail_f = mk(2'd2, 2'b11, 12'h0C3);

    rstn = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    rd_en = '0;
    $display("[TB] reset and credit seeding");
    idle();
    idle();
    checkOutput("reset vc_valid", 64'(vc_valid), 64'h0);
    checkOutput("reset credit", 64'(credit_upd), 64'h0);
    checkOutput("reset init_done", 64'(init_done), 64'h0);
    rstn = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      idle();
      checkOutput($sformatf("seed credit cycle %0d", k), 64'(credit_upd), 64'hF);
      checkOutput($sformatf("seed init_done cycle %0d", k), 64'(init_done), 64'h0);
    end
    idle();
    checkOutput("post-seed credit", 64'(credit_upd), 64'h0);
    checkOutput("post-seed init_done", 64'(init_done), 64'h1);

    $display("[TB] VC2 head/body/tail");
    applyStimulus(1'b1, head_f, '0);
    applyStimulus(1'b1, body_f, '0);
    applyStimulus(1'b1, tail_f, '0);
    checkOutput("vc2 vc_valid", 64'(vc_valid), 64'h4);
    checkOutput("vc2 head", 64'(vc_flit[2*DW +: DW]), 64'(head_f));
    applyStimulus(1'b0, '0, 4'b0100);
    checkOutput("vc2 pop1 credit", 64'(credit_upd), 64'h4);
    checkOutput("vc2 body", 64'(vc_flit[2*DW +: DW]), 64'(body_f));
    applyStimulus(1'b0, '0, 4'b0100);
    checkOutput("vc2 pop2 credit", 64'(credit_upd), 64'h4);
    checkOutput("vc2 tail", 64'(vc_flit[2*DW +: DW]), 64'(tail_f));
    applyStimulus(1'b0, '0, 4'b0100);
    checkOutput("vc2 pop3 credit", 64'(credit_upd), 64'h4);
    checkOutput("vc2 empty", 64'(vc_valid), 64'h0);
    idle();
    checkOutput("vc2 no extra credit", 64'(credit_upd), 64'h0);

    $display("[TB] VC1 overflow");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, mk(2'd1, 2'b10, 12'(i)), '0);
    checkOutput("vc1 no ovf yet", 64'(overflow_err), 64'h0);
    applyStimulus(1'b1, mk(2'd1, 2'b11, 12'h0FF), 4'b0010);
    checkOutput("vc1 ovf", 64'(overflow_err), 64'h1);
    checkOutput("vc1 one credit", 64'(credit_upd), 64'h2);
    checkOutput("vc1 head after pop", 64'(vc_flit[1*DW +: DW]), 64'(mk(2'd1, 2'b10, 12'd1)));
    idle();
    checkOutput("vc1 single credit", 64'(credit_upd), 64'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 4'b0010);
    idle();
    checkOutput("vc1 drained", 64'(vc_valid), 64'h0);

    $display("[TB] VC0 streaming write+read");
    applyStimulus(1'b1, mk(2'd0, 2'b10, 12'd0), '0);
    applyStimulus(1'b1, mk(2'd0, 2'b10, 12'd1), '0);
    cnt = 0;
    for (int i = 2; i < 12; i++) begin
      applyStimulus(1'b1, mk(2'd0, 2'b10, 12'(i)), 4'b0001);
      if (credit_upd[0]) cnt++;
    end
    checkOutput("vc0 credit count", 64'(cnt), 64'd10);
    checkOutput("vc0 head payload", 64'(vc_flit[11:0]), 64'd10);
    idle();
    applyStimulus(1'b0, '0, 4'b0001);
    applyStimulus(1'b0, '0, 4'b0001);
    idle();

    $display("[TB] reads on empty VCs");
    applyStimulus(1'b0, '0, 4'b1111);
    applyStimulus(1'b0, '0, 4'b1111);
    checkOutput("empty rd credit", 64'(credit_upd), 64'h0);
    checkOutput("empty rd vc_valid", 64'(vc_valid), 64'h0);
    idle();

    $display("[TB] reset with flits buffered");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, mk(2'd3, 2'b10, 12'(i)), '0);
    checkOutput("vc3 filled", 64'(vc_valid), 64'h8);
    rstn = 1'b0;
    idle();
    checkOutput("mid reset vc_valid", 64'(vc_valid), 64'h0);
    checkOutput("mid reset ovf", 64'(overflow_err), 64'h0);
    checkOutput("mid reset init_done", 64'(init_done), 64'h0);
    rstn = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      idle();
      checkOutput($sformatf("reseed credit cycle %0d", k), 64'(credit_upd), 64'hF);
    end
    idle();
    checkOutput("reseed init_done", 64'(init_done), 64'h1);
    checkOutput("reseed credit off", 64'(credit_upd), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
